// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and its debounce FSM.
package keypad_scanner_pkg;

    localparam int unsigned KeyW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCand = 2'd1,
        StHeld = 2'd2
    } deb_state_e;

    typedef enum logic [1:0] {
        FrNone   = 2'd0,
        FrSingle = 2'd1,
        FrMulti  = 2'd2
    } frame_res_e;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            default: drv = 4'b0111;
        endcase
        return drv;
    endfunction

    function automatic logic [2:0] row_count(input logic [3:0] pressed);
        return {2'b00, pressed[0]} + {2'b00, pressed[1]}
             + {2'b00, pressed[2]} + {2'b00, pressed[3]};
    endfunction

    function automatic logic [1:0] frame_classify(input logic [1:0] cnt);
        logic [1:0] res;
        case (cnt)
            2'd0:    res = FrNone;
            2'd1:    res = FrSingle;
            default: res = FrMulti;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Frame-level debounce: accepts a key after DEBOUNCE_FRAMES identical single-key frames,
// then waits for DEBOUNCE_FRAMES empty frames before arming again.
module key_debounce_fsm
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            frame_end_i,
    input  logic [1:0]      frame_result_i,
    input  logic [KeyW-1:0] frame_code_i,
    output logic            accept_o,
    output logic [KeyW-1:0] code_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_FRAMES);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    deb_state_e      state;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_inc;
    logic [KeyW-1:0] cand;
    logic            is_single;
    logic            is_none;

    assign cnt_inc   = cnt + CntOne;
    assign is_single = (frame_result_i == FrSingle);
    assign is_none   = (frame_result_i == FrNone);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= StIdle;
            cnt      <= '0;
            cand     <= '0;
            accept_o <= 1'b0;
            code_o   <= '0;
        end else begin
            accept_o <= 1'b0;
            if (frame_end_i) begin
                case (state)
                    StIdle: begin
                        if (is_single) begin
                            cand <= frame_code_i;
                            if (DEBOUNCE_FRAMES == 1) begin
                                accept_o <= 1'b1;
                                code_o   <= frame_code_i;
                                state    <= StHeld;
                                cnt      <= '0;
                            end else begin
                                state <= StCand;
                                cnt   <= CntOne;
                            end
                        end
                    end
                    StCand: begin
                        if (is_single && (frame_code_i == cand)) begin
                            if (cnt_inc == CntMax) begin
                                accept_o <= 1'b1;
                                code_o   <= cand;
                                state    <= StHeld;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else if (is_single) begin
                            cand <= frame_code_i;
                            cnt  <= CntOne;
                        end else begin
                            state <= StIdle;
                            cnt   <= '0;
                        end
                    end
                    StHeld: begin
                        // Any pressed key restarts the release count; no auto-repeat.
                        if (is_none) begin
                            if (cnt_inc == CntMax) begin
                                state <= StIdle;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, row synchroniser, per-frame key
// accumulation and a 16-bit digit shift register feeding the display driver.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ROW,
    input  logic        CLR,
    output logic [3:0]  COL,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_VALID,
    output logic [15:0] DOUT
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div;
    logic [1:0]      col_idx;
    logic [3:0]      rs_meta;
    logic [3:0]      rs;
    logic [1:0]      acc_cnt;
    logic [KeyW-1:0] acc_code;

    logic            tick;
    logic            frame_end;
    logic [3:0]      pressed;
    logic [2:0]      hits;
    logic [1:0]      row_idx;
    logic [2:0]      sum_cnt;
    logic [1:0]      tot_cnt;
    logic [KeyW-1:0] tot_code;
    logic [1:0]      frame_result;

    assign tick      = (div == DivLast);
    assign frame_end = tick && (col_idx == 2'd3);
    assign pressed   = ~rs;
    assign hits      = row_count(pressed);

    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pressed[i]) begin
                row_idx = 2'(i);
            end
        end
    end

    // Counts saturate at 2: beyond that every frame is simply MULTI.
    always_comb begin
        sum_cnt      = {1'b0, acc_cnt} + hits;
        tot_cnt      = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code     = ((acc_cnt == 2'd0) && (hits != 3'd0)) ? {row_idx, col_idx} : acc_code;
        frame_result = frame_classify(tot_cnt);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div      <= '0;
            col_idx  <= 2'd0;
            COL      <= col_drive(2'd0);
            rs_meta  <= 4'b1111;
            rs       <= 4'b1111;
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else begin
            rs_meta <= ROW;
            rs      <= rs_meta;
            if (tick) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                COL     <= col_drive(col_idx + 2'd1);
                if (frame_end) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= tot_cnt;
                    acc_code <= tot_code;
                end
            end else begin
                div <= div + DivW'(1);
            end
        end
    end

    key_debounce_fsm #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .CLK           (CLK),
        .RST           (RST),
        .frame_end_i   (frame_end),
        .frame_result_i(frame_result),
        .frame_code_i  (tot_code),
        .accept_o      (KEY_VALID),
        .code_o        (KEY_CODE)
    );

    // The digit shifts in on the edge that closes the KEY_VALID cycle; a clear in that
    // same cycle wipes the old digits before the shift.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= 16'h0000;
        end else if (CLR) begin
            DOUT <= KEY_VALID ? {12'h000, KEY_CODE} : 16'h0000;
        end else if (KEY_VALID) begin
            DOUT <= {DOUT[11:0], KEY_CODE};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-aligned keypad stimulus with a run-length debounce model and a
// scoreboard monitor that checks every KEY_VALID pulse.
module tb_keypad_scanner;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned DebFrames = 2;
    localparam int unsigned FrameCyc = 4 * ScanDiv;

    logic        CLK;
    logic        RST;
    logic [3:0]  ROW;
    logic        CLR;
    logic [3:0]  COL;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic [15:0] DOUT;

    keypad_scanner #(
        .SCAN_DIV       (ScanDiv),
        .DEBOUNCE_FRAMES(DebFrames)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ROW      (ROW),
        .CLR      (CLR),
        .COL      (COL),
        .KEY_CODE (KEY_CODE),
        .KEY_VALID(KEY_VALID),
        .DOUT     (DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Physical keypad: bit {row,col} of keys closes that switch.
    logic [15:0] keys;
    always_comb begin
        ROW = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            ROW[r] = ~|(keys[r*4 +: 4] & ~COL);
        end
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] dout;
        int          tag;
    } exp_t;

    exp_t        q[$];
    int          ncmp = 0;
    int          nerr = 0;
    int          frame_no = 0;
    bit          clr_pend = 0;

    // Reference model state.
    bit          armed;
    int          run_len;
    logic [3:0]  run_key;
    int          none_run;
    logic [15:0] mdout;
    logic [3:0]  mkey;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        armed    = 1;
        run_len  = 0;
        run_key  = 4'h0;
        none_run = 0;
        mdout    = 16'h0000;
        mkey     = 4'h0;
    endtask

    // Accept after DebFrames consecutive identical single-key frames while armed;
    // re-arm after DebFrames consecutive empty frames.
    task automatic model_frame(input logic [15:0] k, input bit clr);
        int         n;
        logic [3:0] code;
        bit         accept;
        exp_t       e;
        n = $countones(k);
        code = 4'h0;
        for (int i = 0; i < 16; i++) if (k[i]) code = 4'(i);
        accept = 0;
        if (armed) begin
            if (n == 1) begin
                if (run_len > 0 && run_key == code) run_len++;
                else begin
                    run_len = 1;
                    run_key = code;
                end
                if (run_len == DebFrames) begin
                    accept   = 1;
                    armed    = 0;
                    none_run = 0;
                    run_len  = 0;
                end
            end else begin
                run_len = 0;
            end
        end else begin
            if (n == 0) begin
                none_run++;
                if (none_run == DebFrames) armed = 1;
            end else begin
                none_run = 0;
            end
        end
        if (accept) begin
            mkey  = code;
            mdout = clr ? {12'h000, code} : {mdout[11:0], code};
            e.code = code;
            e.dout = mdout;
            e.tag  = frame_no;
            q.push_back(e);
        end else if (clr) begin
            mdout = 16'h0000;
        end
    endtask

    // One full frame; clr asks for CLR in the first cycle of the following frame.
    task automatic run_frame(input logic [15:0] k, input bit clr);
        keys = k;
        CLR = clr_pend;
        clr_pend = clr;
        for (int c = 0; c < FrameCyc; c++) begin
            check("col_drive", {12'h0, COL}, {12'h0, ~(4'b0001 << (c / ScanDiv))});
            @(posedge CLK);
            #1;
            if (c == 0) begin
                CLR = 1'b0;
                check("dout", DOUT, mdout);
                check("key_code", {12'h0, KEY_CODE}, {12'h0, mkey});
                model_frame(k, clr);
            end
        end
        frame_no++;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        CLR = 1'b0;
        clr_pend = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        check("rst_col", {12'h0, COL}, 16'h000E);
        check("rst_valid", {15'h0, KEY_VALID}, 16'h0000);
        check("rst_key_code", {12'h0, KEY_CODE}, 16'h0000);
        check("rst_dout", DOUT, 16'h0000);
    endtask

    // Scoreboard monitor.
    bit          dchk = 0;
    logic [15:0] dexp;
    always @(negedge CLK) begin
        if (dchk) begin
            check("dout_after_accept", DOUT, dexp);
            dchk = 0;
        end
        if (!RST && KEY_VALID) begin
            if (q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_key_valid: got KEY_CODE %h, expected no pulse (t=%0t)",
                         KEY_CODE, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("accept_code", {12'h0, KEY_CODE}, {12'h0, e.code});
                check("accept_frame", 16'(frame_no), 16'(e.tag + 1));
                dexp = e.dout;
                dchk = 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        keys = 16'h0000;
        CLR  = 1'b0;
        RST  = 1'b1;
        model_reset();
        do_reset();

        // Idle scanning.
        repeat (3) run_frame(16'h0000, 0);

        // Key 9 held for 10 frames: a single pulse.
        repeat (10) run_frame(16'h0001 << 9, 0);
        repeat (3) run_frame(16'h0000, 0);

        // Keys 1..4 each held 4 frames, 4 idle frames between.
        for (int k = 1; k <= 4; k++) begin
            repeat (4) run_frame(16'h0001 << k, 0);
            repeat (4) run_frame(16'h0000, 0);
        end

        // Bounce and two-key chord.
        run_frame(16'h0001 << 5, 0);
        repeat (3) run_frame(16'h0000, 0);
        repeat (6) run_frame((16'h0001 << 5) | (16'h0001 << 6), 0);
        repeat (3) run_frame(16'h0000, 0);

        // Clear coinciding with accept of key A, then a lone clear.
        run_frame(16'h0001 << 10, 0);
        run_frame(16'h0001 << 10, 1);
        run_frame(16'h0001 << 10, 0);
        repeat (3) run_frame(16'h0000, 0);
        run_frame(16'h0000, 1);
        repeat (2) run_frame(16'h0000, 0);

        // Reset while a candidate for key 7 is pending, key kept held.
        run_frame(16'h0001 << 7, 0);
        keys = 16'h0001 << 7;
        repeat (6) @(posedge CLK);
        #1;
        do_reset();
        repeat (3) run_frame(16'h0001 << 7, 0);
        repeat (3) run_frame(16'h0000, 0);

        // Randomised key sessions.
        for (int b = 0; b < 14; b++) begin
            int          kind;
            int          hold;
            int          k1;
            int          k2;
            logic [15:0] kv;
            kind = int'($urandom_range(0, 5));
            k1 = int'($urandom_range(0, 15));
            k2 = (k1 + int'($urandom_range(1, 15))) % 16;
            if (kind == 0) kv = 16'h0000;
            else if (kind == 1) kv = (16'h0001 << k1) | (16'h0001 << k2);
            else kv = 16'h0001 << k1;
            hold = int'($urandom_range(1, 4));
            for (int h = 0; h < hold; h++) run_frame(kv, ($urandom_range(0, 7) == 0));
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) run_frame(16'h0000, 0);
        end
        repeat (4) run_frame(16'h0000, 0);

        check("pulses_outstanding", 16'(q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner: the input-side counterpart of the team's multiplexed 4-digit seven-segment display driver.
- Drives active-low one-cold column selects, samples active-low rows and debounces over full scan frames.
- Emits a 4-bit hex key code with a one-cycle valid pulse.
- Shifts each accepted digit into a 16-bit register; DOUT connects directly to the display driver's 16-bit data input.

Parameters:
- SCAN_DIV, 50000: CLK cycles per column period (>=2).
- DEBOUNCE_FRAMES, 4: consecutive identical full frames needed to accept a press or a release (>=1).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- ROW  in  4  keypad rows, active-low (pulled up); asynchronous to CLK
- CLR  in  1  synchronous clear of DOUT
- COL  out 4  column drive, active-low one-cold
- KEY_CODE  out 4  last accepted key, {row_idx[1:0], col_idx[1:0]}
- KEY_VALID  out 1  one-cycle pulse per accepted press
- DOUT  out 16  entered digits, newest in [3:0]

Behaviour:
- Reset (RST high at a CLK edge): COL=4'b1110, column index 0, divider 0, ROW synchroniser=4'b1111, frame accumulator cleared, FSM=IDLE, debounce count 0, KEY_CODE=0, KEY_VALID=0, DOUT=0. Applies mid-frame and mid-debounce; any partial candidate is discarded.
- ROW passes through a 2-flop synchroniser (rs) before any use.
- Divider counts 0..SCAN_DIV-1 and wraps. tick = (div==SCAN_DIV-1).
- Sampling and column advance:
  - On tick, sample rs for the current column (the last cycle of the column period).
  - At the same edge, advance the column index 0->1->2->3->0. COL changes the cycle after tick.
  - COL values: col 0=1110, col 1=1101, col 2=1011, col 3=0111.
- Pressed detection: rs[i]==0 while column j is driven means key {i,j} is pressed.
- Frame accumulator:
  - Counts pressed keys over the 4 columns and records the code of the pressed key.
  - Frame ends on the tick of column 3.
  - Frame result is NONE (0 keys), SINGLE(k) (exactly one key) or MULTI (>=2 keys).
  - MULTI is treated as NONE for acceptance.
- Debounce FSM, evaluated once per frame end:
  - IDLE: SINGLE(k) -> CAND, cand=k, cnt=1. If DEBOUNCE_FRAMES==1, go directly to accept.
  - CAND:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_FRAMES -> accept.
    - SINGLE(k'), k' differs from cand: stay CAND, cand=k', cnt=1.
    - NONE or MULTI: -> IDLE.
  - Accept action:
    - KEY_VALID=1 for exactly the next CLK cycle.
    - KEY_CODE=cand; holds until the next accept.
    - DOUT={DOUT[11:0], cand}.
    - FSM -> HELD, cnt=0.
  - HELD:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_FRAMES -> IDLE.
    - Any pressed key(s): cnt=0, stay HELD. Never auto-repeat; a second key while held is ignored.
- CLR: DOUT<=0. If CLR coincides with an accept, DOUT={12'h000, cand} (clear first, then shift). CLR does not affect the FSM or KEY_CODE.
- Latency: stable press -> KEY_VALID no later than (DEBOUNCE_FRAMES+1) x 4 x SCAN_DIV + 3 cycles after the press.

Decomposition:
- Shared package: FSM state encodings (IDLE, CAND, HELD), column one-cold table, key code width (4), frame result encoding (NONE/SINGLE/MULTI).
- One sub-module: key_debounce_fsm. Inputs: frame_end, frame_result, frame_code. Outputs: accept pulse, accepted code.
- Divider, column rotation, synchroniser and DOUT shift register stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2; one frame = 16 cycles):
1. Reset, no keys -> COL steps 1110,1101,1011,0111 every 4 cycles and wraps; KEY_VALID never asserted; DOUT=0x0000.
2. Model pulls ROW[2] low whenever COL[1]==0, held for 10 frames -> exactly one KEY_VALID pulse, KEY_CODE=4'h9, DOUT=0x0009, no repeat.
3. Press/release keys 0x1 (r0c1), 0x2 (r0c2), 0x3 (r0c3), 0x4 (r1c0), each held 4 frames with 4 idle frames between -> four pulses, DOUT=0x1234.
4. Key 0x5 pressed for a single frame, then released (bounce); also keys 0x5 and 0x6 pressed together for 6 frames -> no KEY_VALID, DOUT unchanged.
5. CLR asserted in the same cycle as an accept of key 0xA with DOUT=0x1234 -> DOUT=0x000A; CLR alone later -> DOUT=0x0000 and KEY_CODE stays 0xA.
6. RST pulsed while in CAND for key 0x7, key kept held -> all outputs return to reset values; a fresh 2-frame debounce follows before KEY_VALID, with DOUT=0x0007.
